twiddle_seq: RTL and testbench
==============================

Name: twiddle_seq

Overview:
- Upstream feeder for the Q1.15 complex multiplier in the FFT64 radix-2 SDF datapath.
- Accepts the butterfly output stream and tracks the sample index within each N-point frame.
- Emits each sample one cycle later, aligned with the twiddle factor W_N^k and a bypass flag. The multiplier consumes data and twiddle together; the bypass flag selects the unmultiplied data where the twiddle is 1.
- One instance per SDF stage; stages differ only in M.

Parameters:
- WIDTH, 16, data and twiddle width, signed Q1.15.
- N, 64, FFT frame length, power of 2.
- LOG_N, 6, log2(N).
- M, 64, butterfly block span of this stage, power of 2, 2 <= M <= N.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous frame realign.
- di_en  in  1  input sample valid.
- di_re  in  WIDTH  input real part.
- di_im  in  WIDTH  input imaginary part.
- do_en  out  1  output sample valid.
- do_re  out  WIDTH  delayed real part.
- do_im  out  WIDTH  delayed imaginary part.
- tw_re  out  WIDTH  twiddle real part, cos(2πk/N).
- tw_im  out  WIDTH  twiddle imaginary part, -sin(2πk/N).
- tw_bypass  out  1  1 = twiddle is unity, skip the multiply.
- do_idx  out  LOG_N  frame index of the output sample.
- do_sof  out  1  start of frame, do_idx==0 with do_en.

Behaviour:
- Single clock domain. Asynchronous active-low reset, deasserted synchronously upstream.
- Reset values: do_en=0, do_sof=0, do_re=0, do_im=0, tw_re=32767, tw_im=0, tw_bypass=1, do_idx=0. Internal index counter idx=0.
- Streaming only: no backpressure, gaps allowed.
  - Each cycle with di_en=1 is one sample.
  - The counter advances only on di_en.
- Latency is exactly 1 cycle. All outputs are registered. do_en(t+1)=di_en(t).
- Cycle with di_en=1, using the current index j:
  - do_re/do_im <= di_re/di_im; do_idx <= j; do_sof <= (j==0).
  - Let r = j mod M.
  - If r < M/2: tw_bypass<=1, tw_re<=32767, tw_im<=0.
  - Else: k=(r-M/2)*(N/M), range 0..N/2-1. tw_bypass<=(k==0); tw_re/tw_im <= ROM[k].
  - idx <= (j==N-1) ? 0 : j+1. Wrap-around is silent, with no flag beyond do_sof on the next frame.
- Cycle with di_en=0:
  - do_en<=0, do_sof<=0.
  - do_re, do_im, tw_*, tw_bypass and do_idx hold their previous values.
  - idx is unchanged.
- clear=1:
  - The current cycle's sample, if di_en=1, is processed as j=0. Then idx<=1.
  - If di_en=0, idx<=0.
  - clear has priority over the normal increment.
- Reset mid-frame: all state returns to reset values immediately. The partial frame is discarded; the next valid sample is index 0.
- ROM:
  - N/2 entries, combinational table inside the block. Must be correct for any power-of-2 N up to 1024; generated at elaboration or as a case table.
  - Entry k: re = round(32768*cos(2πk/N)), im = round(-32768*sin(2πk/N)), round half away from zero.
  - Results are clamped to [-32768, 32767]. Only +1.0 saturates, to 32767.
  - For N=64: k=8 gives (23170,-23170); k=16 gives (0,-32768); k=24 gives (-23170,-23170).
- No arithmetic on the data path; data passes bit-exact.

Test Plan:
- Reset then 64 consecutive valid samples, di_re=j, di_im=-j, M=64:
  - Samples 0..31: tw_bypass=1, tw=(32767,0).
  - Sample 32: bypass=1, (32767,0).
  - Sample 40: (23170,-23170), bypass=0.
  - Sample 48: (0,-32768).
  - Sample 56: (-23170,-23170).
  - do_* equals the input delayed by exactly 1 cycle; do_sof only at j=0.
- M=16, N=64, 64 samples:
  - Sample 12 (r=12, k=16): (0,-32768).
  - Sample 8: bypass=1.
  - Sample 20 (r=4): bypass=1.
  - Sample 31 (r=15, k=28): (23170·… per ROM, i.e. round(32768*cos(7π/8)) = -30274, -12540).
- Gapped stream, di_en toggling 1,0,0,1:
  - Indices advance only on valid cycles.
  - Outputs hold during gaps, with do_en=0.
- 130 continuous samples:
  - do_idx wraps 63→0.
  - do_sof pulses at output samples 0, 64 and 128.
- clear asserted with di_en=1 at index 37:
  - That sample is output with do_idx=0 and do_sof=1.
  - The next sample has do_idx=1.
- reset_n pulsed low mid-cycle at index 20:
  - Outputs go to reset values immediately, without waiting for a clock.
  - The first valid sample after release has do_idx=0.

Source files
------------

// File: rtl/twiddle_seq.sv
// Per-stage twiddle feeder for the FFT SDF pipeline: delays each sample by one cycle
// and pairs it with W_N^k and a unity-bypass flag for the downstream complex multiplier.
module twiddle_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 64,
  parameter int unsigned LOG_N = 6,
  parameter int unsigned M     = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic                    di_en,
  input  logic signed [WIDTH-1:0] di_re,
  input  logic signed [WIDTH-1:0] di_im,
  output logic                    do_en,
  output logic signed [WIDTH-1:0] do_re,
  output logic signed [WIDTH-1:0] do_im,
  output logic signed [WIDTH-1:0] tw_re,
  output logic signed [WIDTH-1:0] tw_im,
  output logic                    tw_bypass,
  output logic [LOG_N-1:0]        do_idx,
  output logic                    do_sof
);

  localparam int unsigned KW     = LOG_N - 1;
  localparam int unsigned HALF   = M / 2;
  localparam int unsigned SH     = $clog2(N / M);
  localparam int          MAXV   = (1 << (WIDTH - 1)) - 1;
  localparam int          MINV   = -MAXV - 1;
  localparam real         SCALE  = real'(MAXV) + 1.0;
  localparam real         TWO_PI = 6.283185307179586;

  logic signed [WIDTH-1:0] rom_re [N/2];
  logic signed [WIDTH-1:0] rom_im [N/2];

  // Twiddle ROM, rounded half away from zero; only cos(0) = +1.0 actually saturates
  for (genvar g = 0; g < N / 2; g++) begin : g_rom
    localparam real C  = SCALE * $cos(TWO_PI * real'(g) / real'(N));
    localparam real S  = -SCALE * $sin(TWO_PI * real'(g) / real'(N));
    localparam int  CR = (C >= 0.0) ? $rtoi(C + 0.5) : -$rtoi(0.5 - C);
    localparam int  SR = (S >= 0.0) ? $rtoi(S + 0.5) : -$rtoi(0.5 - S);
    localparam int  CS = (CR > MAXV) ? MAXV : ((CR < MINV) ? MINV : CR);
    localparam int  SS = (SR > MAXV) ? MAXV : ((SR < MINV) ? MINV : SR);
    assign rom_re[g] = WIDTH'(CS);
    assign rom_im[g] = WIDTH'(SS);
  end

  logic [LOG_N-1:0]        idx_q, idx_d;
  logic                    en_q, en_d;
  logic                    sof_q, sof_d;
  logic                    byp_q, byp_d;
  logic signed [WIDTH-1:0] re_q, re_d, im_q, im_d;
  logic signed [WIDTH-1:0] twr_q, twr_d, twi_q, twi_d;
  logic [LOG_N-1:0]        oidx_q, oidx_d;

  logic [LOG_N-1:0] j_c, r_c, rel_c;
  logic [KW-1:0]    k_c;

  // clear realigns the frame so the current sample is treated as index 0
  assign j_c   = clear ? '0 : idx_q;
  assign r_c   = j_c & LOG_N'(M - 1);
  assign rel_c = r_c - LOG_N'(HALF);
  assign k_c   = KW'(rel_c << SH);

  always_comb begin
    idx_d  = idx_q;
    en_d   = 1'b0;
    sof_d  = 1'b0;
    byp_d  = byp_q;
    re_d   = re_q;
    im_d   = im_q;
    twr_d  = twr_q;
    twi_d  = twi_q;
    oidx_d = oidx_q;
    if (di_en) begin
      en_d   = 1'b1;
      re_d   = di_re;
      im_d   = di_im;
      oidx_d = j_c;
      sof_d  = (j_c == '0);
      if (r_c < LOG_N'(HALF)) begin
        byp_d = 1'b1;
        twr_d = WIDTH'(MAXV);
        twi_d = '0;
      end else begin
        byp_d = (k_c == '0);
        twr_d = rom_re[k_c];
        twi_d = rom_im[k_c];
      end
      idx_d = (j_c == LOG_N'(N - 1)) ? '0 : j_c + LOG_N'(1);
    end else if (clear) begin
      idx_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q  <= '0;
      en_q   <= 1'b0;
      sof_q  <= 1'b0;
      byp_q  <= 1'b1;
      re_q   <= '0;
      im_q   <= '0;
      twr_q  <= WIDTH'(MAXV);
      twi_q  <= '0;
      oidx_q <= '0;
    end else begin
      idx_q  <= idx_d;
      en_q   <= en_d;
      sof_q  <= sof_d;
      byp_q  <= byp_d;
      re_q   <= re_d;
      im_q   <= im_d;
      twr_q  <= twr_d;
      twi_q  <= twi_d;
      oidx_q <= oidx_d;
    end
  end

  assign do_en     = en_q;
  assign do_sof    = sof_q;
  assign tw_bypass = byp_q;
  assign do_re     = re_q;
  assign do_im     = im_q;
  assign tw_re     = twr_q;
  assign tw_im     = twi_q;
  assign do_idx    = oidx_q;

endmodule

// File: tb/tb_twiddle_seq.sv
// Scoreboard bench for twiddle_seq: two stages (M=64 and M=16) share one stimulus stream;
// expected outputs are queued at issue time and popped by a monitor on each do_en.
module tb_twiddle_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, clr, en;
  logic signed [15:0] dre, dim;

  logic               a_en, a_byp, a_sof, b_en, b_byp, b_sof;
  logic signed [15:0] a_re, a_im, a_twr, a_twi, b_re, b_im, b_twr, b_twi;
  logic [5:0]         a_idx, b_idx;

  twiddle_seq #(.WIDTH(16), .N(64), .LOG_N(6), .M(64)) u_m64 (
    .clock(clk), .reset_n(rst_n), .clear(clr), .di_en(en), .di_re(dre), .di_im(dim),
    .do_en(a_en), .do_re(a_re), .do_im(a_im), .tw_re(a_twr), .tw_im(a_twi),
    .tw_bypass(a_byp), .do_idx(a_idx), .do_sof(a_sof));

  twiddle_seq #(.WIDTH(16), .N(64), .LOG_N(6), .M(16)) u_m16 (
    .clock(clk), .reset_n(rst_n), .clear(clr), .di_en(en), .di_re(dre), .di_im(dim),
    .do_en(b_en), .do_re(b_re), .do_im(b_im), .tw_re(b_twr), .tw_im(b_twi),
    .tw_bypass(b_byp), .do_idx(b_idx), .do_sof(b_sof));

  typedef struct {
    logic signed [15:0] re, im, twr, twi;
    logic [5:0]         idx;
    logic               sof, byp, twchk;
    int                 cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   midx   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected response; twiddles are hand-computed for N=64 at k multiples of 4
  function automatic exp_t mk(input int j, input int m, input int re, input int im, input int c);
    exp_t e;
    int r, h, k, tr, ti;
    e.re = 16'(re); e.im = 16'(im); e.idx = 6'(j); e.sof = (j == 0); e.cyc = c;
    e.twchk = 1'b1;
    r = j % m; h = m / 2; tr = 32767; ti = 0;
    if (r < h) begin
      e.byp = 1'b1;
    end else begin
      k = (r - h) * (64 / m);
      e.byp = (k == 0);
      case (k)
        0:  begin tr = 32767;  ti = 0;      end
        4:  begin tr = 30274;  ti = -12540; end
        8:  begin tr = 23170;  ti = -23170; end
        12: begin tr = 12540;  ti = -30274; end
        16: begin tr = 0;      ti = -32768; end
        20: begin tr = -12540; ti = -30274; end
        24: begin tr = -23170; ti = -23170; end
        28: begin tr = -30274; ti = -12540; end
        default: e.twchk = 1'b0;
      endcase
    end
    e.twr = 16'(tr); e.twi = 16'(ti);
    return e;
  endfunction

  task automatic cmp(input string t, input exp_t e,
                     input logic signed [15:0] re, input logic signed [15:0] im,
                     input logic signed [15:0] twr, input logic signed [15:0] twi,
                     input logic [5:0] idx, input logic sof, input logic byp);
    string n;
    n = $sformatf("%s[j=%0d]", t, e.idx);
    chk({n, ".re"},  re,  e.re);
    chk({n, ".im"},  im,  e.im);
    chk({n, ".idx"}, idx, e.idx);
    chk({n, ".sof"}, sof, e.sof);
    chk({n, ".byp"}, byp, e.byp);
    chk({n, ".latency_cycle"}, cyc, e.cyc);
    if (e.twchk) begin
      chk({n, ".tw_re"}, twr, e.twr);
      chk({n, ".tw_im"}, twi, e.twi);
    end
  endtask

  // Monitor: pops one expectation per presented output sample
  always @(negedge clk) begin
    if (a_en) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL m64.unexpected_output: got idx %0d expected no output", a_idx);
      end else cmp("m64", qa.pop_front(), a_re, a_im, a_twr, a_twi, a_idx, a_sof, a_byp);
    end
    if (b_en) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL m16.unexpected_output: got idx %0d expected no output", b_idx);
      end else cmp("m16", qb.pop_front(), b_re, b_im, b_twr, b_twi, b_idx, b_sof, b_byp);
    end
  end

  task automatic send(input int re, input int im, input bit c);
    int j;
    @(posedge clk); #1;
    en = 1'b1; dre = 16'(re); dim = 16'(im); clr = c;
    j = c ? 0 : midx;
    qa.push_back(mk(j, 64, re, im, cyc + 1));
    qb.push_back(mk(j, 16, re, im, cyc + 1));
    midx = (j == 63) ? 0 : j + 1;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    en = 1'b0; clr = 1'b0;
  endtask

  task automatic chk_rst(input string t, input logic en_o, input logic sof_o, input logic byp_o,
                         input logic signed [15:0] re, input logic signed [15:0] im,
                         input logic signed [15:0] twr, input logic signed [15:0] twi,
                         input logic [5:0] idx);
    chk({t, ".rst_do_en"}, en_o, 0);
    chk({t, ".rst_do_sof"}, sof_o, 0);
    chk({t, ".rst_bypass"}, byp_o, 1);
    chk({t, ".rst_do_re"}, re, 0);
    chk({t, ".rst_do_im"}, im, 0);
    chk({t, ".rst_tw_re"}, twr, 32767);
    chk({t, ".rst_tw_im"}, twi, 0);
    chk({t, ".rst_do_idx"}, idx, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; dre = '0; dim = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_rst("m64", a_en, a_sof, a_byp, a_re, a_im, a_twr, a_twi, a_idx);
    chk_rst("m16", b_en, b_sof, b_byp, b_re, b_im, b_twr, b_twi, b_idx);
    @(negedge clk); rst_n = 1'b1;

    // One full frame with di_re=j, di_im=-j
    for (int j = 0; j < 64; j++) send(j, -j, 1'b0);
    // 130 back-to-back samples: index wraps twice, sof at outputs 0, 64, 128
    for (int i = 0; i < 130; i++) send(1000 + i, 500 - i, 1'b0);

    // clear with a valid sample at index 37
    while (midx != 37) send(300 + midx, -300 - midx, 1'b0);
    send(555, -555, 1'b1);
    send(556, -556, 1'b0);

    // Gap after a twiddled sample at index 44: outputs must hold with do_en low
    while (midx != 44) send(400 + midx, -400 - midx, 1'b0);
    send(7777, -7777, 1'b0);
    idle();
    idle();
    chk("gap.m64.do_en", a_en, 0);
    chk("gap.m64.do_sof", a_sof, 0);
    chk("gap.m64.do_re", a_re, 7777);
    chk("gap.m64.do_im", a_im, -7777);
    chk("gap.m64.do_idx", a_idx, 44);
    chk("gap.m64.tw_re", a_twr, 12540);
    chk("gap.m64.tw_im", a_twi, -30274);
    chk("gap.m64.bypass", a_byp, 0);
    chk("gap.m16.do_en", b_en, 0);
    chk("gap.m16.tw_re", b_twr, 0);
    chk("gap.m16.tw_im", b_twi, -32768);
    chk("gap.m16.do_idx", b_idx, 44);
    send(8888, -8888, 1'b0);

    // Asynchronous reset mid-cycle at index 20
    while (midx != 20) send(600 + midx, -600 - midx, 1'b0);
    idle();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_rst("m64.async", a_en, a_sof, a_byp, a_re, a_im, a_twr, a_twi, a_idx);
    chk_rst("m16.async", b_en, b_sof, b_byp, b_re, b_im, b_twr, b_twi, b_idx);
    chk("async.queue_drained", qa.size() + qb.size(), 0);
    qa.delete(); qb.delete();
    midx = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(42, -42, 1'b0);
    send(43, -43, 1'b0);
    idle();
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("end.m64_queue_empty", qa.size(), 0);
    chk("end.m16_queue_empty", qb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
